riscv_retire_monitor: RTL and testbench

//  Synthesizable performance/completion monitor downstream of the dual-issue core's writeback stage.

---
 rtl/riscv_mon_pkg.sv | 33 +++
 rtl/riscv_mon_sat_cnt.sv | 39 +++
 rtl/riscv_retire_monitor.sv | 145 ++++++++++++++
 tb/tb_riscv_retire_monitor.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mon_pkg.sv
// riscv_mon_pkg: shared types and constants for the retire monitor.
//   mon_state_e  - monitor FSM states
//   OPC_SYSTEM / F3_CSRRW - end-of-test instruction decode fields
//   RD_*         - read-port address map
//   SO_*         - encoding reported on state_o
package riscv_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } mon_state_e;

    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [2:0] F3_CSRRW   = 3'b001;

    localparam logic [1:0] RD_CYCLE_LO   = 2'd0;
    localparam logic [1:0] RD_CYCLE_HI   = 2'd1;
    localparam logic [1:0] RD_INSTRET_LO = 2'd2;
    localparam logic [1:0] RD_INSTRET_HI = 2'd3;

    localparam logic [1:0] SO_IDLE  = 2'd0;
    localparam logic [1:0] SO_RUN   = 2'd1;
    localparam logic [1:0] SO_DRAIN = 2'd2;
    localparam logic [1:0] SO_DONE  = 2'd3;

    function automatic logic is_csrrw(input logic vld, input logic [31:0] op);
        return vld && (op[6:0] == OPC_SYSTEM) && (op[14:12] == F3_CSRRW);
    endfunction

endpackage

// File: rtl/riscv_mon_sat_cnt.sv
// riscv_mon_sat_cnt: W-bit counter with synchronous clear, enable and a
// 2-bit increment; sticks at all-ones instead of wrapping.
//   clk, rst  - clock, async active-low reset
//   clr_i     - clear to zero (wins over en_i)
//   en_i      - add inc_i this cycle
//   inc_i     - increment amount 0..3
//   cnt_o     - current count
module riscv_mon_sat_cnt #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [1:0]   inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W:0]   sum;

    always_comb begin
        // one extra bit catches the carry out; any carry means saturate
        sum   = {1'b0, cnt_q} + {{(W-1){1'b0}}, inc_i};
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = sum[W] ? '1 : sum[W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/riscv_retire_monitor.sv
// riscv_retire_monitor: counts cycles and retired instructions of the
// dual-issue core, stops after the end-of-test CSRRW plus a drain window,
// or flags a timeout.
//   clk, rst                 - clock, async active-low reset
//   start_i                  - arm request (IDLE/DONE/TIMEOUT only)
//   pipe0/1_valid_wb_i       - retirements this cycle
//   exec0_valid_i/opcode_i   - exec0 instruction for end-of-test detect
//   rd_addr_i / rd_data_o    - 32-bit register read, 1-cycle latency
//   state_o, done_o, timeout_o - registered status
//   cycle_count_o, instret_count_o - live counters
module riscv_retire_monitor
    import riscv_mon_pkg::*;
#(
    parameter int CNT_W          = 64,
    parameter int DRAIN_CYCLES   = 10,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             pipe0_valid_wb_i,
    input  logic             pipe1_valid_wb_i,
    input  logic             exec0_valid_i,
    input  logic [31:0]      exec0_opcode_i,
    input  logic [1:0]       rd_addr_i,
    output logic [31:0]      rd_data_o,
    output logic [1:0]       state_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] cycle_count_o,
    output logic [CNT_W-1:0] instret_count_o
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]    DRAIN_INIT = DW'(DRAIN_CYCLES - 1);
    // counter value that becomes TIMEOUT_CYCLES on this cycle's increment
    localparam logic [CNT_W-1:0] TO_PRE     = CNT_W'(TIMEOUT_CYCLES - 1);

    mon_state_e    state_q;
    logic [DW-1:0] drain_q;
    logic [1:0]    state_enc_q;
    logic          done_q, timeout_q;
    logic [31:0]   rd_data_q, rd_data_d;

    logic       cnt_clr, cnt_en, csrrw_hit, to_hit;
    logic [1:0] ret_inc;
    logic [63:0] cyc64, ins64;

    assign cnt_clr   = start_i && (state_q == ST_IDLE || state_q == ST_DONE ||
                                   state_q == ST_TIMEOUT);
    assign cnt_en    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign ret_inc   = {1'b0, pipe0_valid_wb_i} + {1'b0, pipe1_valid_wb_i};
    assign csrrw_hit = is_csrrw(exec0_valid_i, exec0_opcode_i);
    assign to_hit    = (cycle_count_o == TO_PRE);

    riscv_mon_sat_cnt #(.W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .inc_i (2'd1),
        .cnt_o (cycle_count_o)
    );

    riscv_mon_sat_cnt #(.W(CNT_W)) u_ins_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .inc_i (ret_inc),
        .cnt_o (instret_count_o)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            drain_q     <= '0;
            state_enc_q <= SO_IDLE;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                    if (start_i) begin
                        state_q     <= ST_RUN;
                        state_enc_q <= SO_RUN;
                        done_q      <= 1'b0;
                        timeout_q   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // detect takes priority over a coincident timeout
                    if (csrrw_hit) begin
                        state_q     <= ST_DRAIN;
                        state_enc_q <= SO_DRAIN;
                        drain_q     <= DRAIN_INIT;
                    end else if (to_hit) begin
                        state_q     <= ST_TIMEOUT;
                        state_enc_q <= SO_DONE;
                        timeout_q   <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == '0) begin
                        state_q     <= ST_DONE;
                        state_enc_q <= SO_DONE;
                        done_q      <= 1'b1;
                    end else begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    state_enc_q <= SO_IDLE;
                end
            endcase
        end
    end

    // live counters, no snapshot: halves are only coherent once frozen
    assign cyc64 = 64'(cycle_count_o);
    assign ins64 = 64'(instret_count_o);

    always_comb begin
        rd_data_d = '0;
        case (rd_addr_i)
            RD_CYCLE_LO:   rd_data_d = cyc64[31:0];
            RD_CYCLE_HI:   rd_data_d = cyc64[63:32];
            RD_INSTRET_LO: rd_data_d = ins64[31:0];
            RD_INSTRET_HI: rd_data_d = ins64[63:32];
            default:       rd_data_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_data_q <= '0;
        else      rd_data_q <= rd_data_d;
    end

    assign rd_data_o = rd_data_q;
    assign state_o   = state_enc_q;
    assign done_o    = done_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_riscv_retire_monitor.sv
module tb_riscv_retire_monitor;

    localparam logic [31:0] OP_CSRRW = 32'h7C001073;
    localparam logic [31:0] OP_NOP   = 32'h00000013;

    logic        clk, rst, start_i;
    logic        p0, p1, ev;
    logic [31:0] op;
    logic [1:0]  rd_addr;
    logic [31:0] rd_data;
    logic [1:0]  state;
    logic        done, tmo;
    logic [63:0] cyc_cnt, ins_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        logic        ev;
        logic [31:0] op;
        logic [1:0]  exp_state;
    } dec_vec_t;

    rd_vec_t     rd_tab[4];
    dec_vec_t    dec_tab[5];
    logic [31:0] sb_q[$];

    riscv_retire_monitor #(
        .CNT_W(64), .DRAIN_CYCLES(10), .TIMEOUT_CYCLES(50000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .pipe0_valid_wb_i (p0),
        .pipe1_valid_wb_i (p1),
        .exec0_valid_i    (ev),
        .exec0_opcode_i   (op),
        .rd_addr_i        (rd_addr),
        .rd_data_o        (rd_data),
        .state_o          (state),
        .done_o           (done),
        .timeout_o        (tmo),
        .cycle_count_o    (cyc_cnt),
        .instret_count_o  (ins_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // drive at negedge, let one posedge pass, return at the next negedge
    task automatic cyc(input logic a0, input logic a1, input logic v, input logic [31:0] o);
        p0 = a0; p1 = a1; ev = v; op = o;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start();
        start_i = 1'b1;
        cyc(0, 0, 0, OP_NOP);
        start_i = 1'b0;
    endtask

    initial begin
        int ins_exp;
        int k;
        logic [31:0] exp_rd;

        rd_tab[0] = '{2'd0, 32'h0000_0005};
        rd_tab[1] = '{2'd1, 32'h0000_0001};
        rd_tab[2] = '{2'd2, 32'h1234_5678};
        rd_tab[3] = '{2'd3, 32'hCAFE_F00D};

        dec_tab[0] = '{1'b1, 32'h00002073, 2'd1};   // CSRRS
        dec_tab[1] = '{1'b0, OP_CSRRW,     2'd1};   // not valid
        dec_tab[2] = '{1'b1, 32'h00001033, 2'd1};   // f3=001, not SYSTEM
        dec_tab[3] = '{1'b1, 32'h00000073, 2'd1};   // ECALL
        dec_tab[4] = '{1'b1, OP_CSRRW,     2'd2};   // CSRRW

        rst = 1'b0; start_i = 1'b0; p0 = 0; p1 = 0; ev = 0; op = OP_NOP; rd_addr = 2'd0;
        #2;
        chk("rst_state", state, 0);
        chk("rst_done", done, 0);
        chk("rst_tmo", tmo, 0);
        chk("rst_cyc", cyc_cnt, 0);
        chk("rst_ins", ins_cnt, 0);
        chk("rst_rd", rd_data, 0);
        @(negedge clk);
        rst = 1'b1;

        // 1: 100 RUN cycles, CSRRW, 10 drain cycles
        do_start();
        chk("t1_run", state, 1);
        ins_exp = 0;
        for (int i = 0; i <= 110; i++) begin
            cyc(1, (i % 2) == 0, i == 100, (i == 100) ? OP_CSRRW : OP_NOP);
            ins_exp += 1 + (((i % 2) == 0) ? 1 : 0);
            if (i == 100) chk("t1_drain", state, 2);
            if (i == 109) chk("t1_notdone", done, 0);
        end
        chk("t1_done", done, 1);
        chk("t1_state", state, 3);
        chk("t1_cyc", cyc_cnt, 111);
        chk("t1_ins", ins_cnt, 64'(ins_exp));
        repeat (3) cyc(1, 1, 0, OP_NOP);
        chk("t1_frz_cyc", cyc_cnt, 111);
        chk("t1_frz_ins", ins_cnt, 64'(ins_exp));
        chk("t1_hold", done, 1);

        // 2: timeout; start_i pulsed mid-RUN must be ignored
        do_start();
        chk("t2_clr", cyc_cnt, 0);
        chk("t2_flag", done, 0);
        k = 0;
        for (int n = 1; n <= 60000; n++) begin
            start_i = (n == 100);
            cyc(0, 0, 0, OP_NOP);
            if (tmo) begin k = n; break; end
        end
        start_i = 1'b0;
        chk("t2_to_iter", k, 50000);
        chk("t2_cyc", cyc_cnt, 50000);
        chk("t2_done", done, 0);
        chk("t2_state", state, 3);
        repeat (5) cyc(1, 1, 0, OP_NOP);
        chk("t2_frz_cyc", cyc_cnt, 50000);
        chk("t2_frz_ins", ins_cnt, 0);
        chk("t2_hold", tmo, 1);

        // 3: CSRRW coincides with the timeout cycle
        do_start();
        chk("t3_tmo_clr", tmo, 0);
        chk("t3_run", state, 1);
        cyc(0, 0, 0, OP_NOP);
        force dut.u_cyc_cnt.cnt_q = 64'd49990;
        #1 release dut.u_cyc_cnt.cnt_q;
        repeat (9) cyc(0, 0, 0, OP_NOP);
        chk("t3_pre_cyc", cyc_cnt, 49999);
        chk("t3_pre_state", state, 1);
        cyc(0, 0, 1, OP_CSRRW);
        chk("t3_drain", state, 2);
        chk("t3_no_tmo", tmo, 0);
        chk("t3_cyc", cyc_cnt, 50000);
        repeat (9) cyc(0, 0, 0, OP_NOP);
        chk("t3_notdone", done, 0);
        cyc(0, 0, 0, OP_NOP);
        chk("t3_done", done, 1);
        chk("t3_tmo", tmo, 0);
        chk("t3_fin_cyc", cyc_cnt, 50010);

        // 4: instret saturation
        do_start();
        force dut.u_ins_cnt.cnt_q = 64'hFFFF_FFFF_FFFF_FFFE;
        #1 release dut.u_ins_cnt.cnt_q;
        cyc(1, 1, 0, OP_NOP);
        chk("t4_sat", ins_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc(1, 1, 0, OP_NOP);
        chk("t4_hold", ins_cnt, 64'hFFFF_FFFF_FFFF_FFFF);

        // 5: async reset in the 5th RUN cycle
        do_start();
        repeat (4) cyc(1, 0, 0, OP_NOP);
        rst = 1'b0;
        #1;
        chk("t5_state", state, 0);
        chk("t5_cyc", cyc_cnt, 0);
        chk("t5_ins", ins_cnt, 0);
        chk("t5_flags", {done, tmo}, 0);
        chk("t5_rd", rd_data, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) cyc(1, 1, 0, OP_NOP);
        chk("t5_idle", state, 0);
        chk("t5_idle_cyc", cyc_cnt, 0);

        // 6: read port in DONE with cycle = 0x1_0000_0005
        do_start();
        force dut.u_cyc_cnt.cnt_q = 64'h0000_0000_FFFF_FFFA;
        force dut.u_ins_cnt.cnt_q = 64'hCAFE_F00D_1234_5678;
        #1;
        release dut.u_cyc_cnt.cnt_q;
        release dut.u_ins_cnt.cnt_q;
        cyc(0, 0, 1, OP_CSRRW);
        repeat (10) cyc(0, 0, 0, OP_NOP);
        chk("t6_done", done, 1);
        chk("t6_cyc", cyc_cnt, 64'h1_0000_0005);
        for (int i = 0; i < 4; i++) begin
            rd_addr = rd_tab[i].addr;
            sb_q.push_back(rd_tab[i].exp);
            cyc(0, 0, 0, OP_NOP);
            if (sb_q.size() != 0) begin
                exp_rd = sb_q.pop_front();
                chk($sformatf("t6_rd%0d", i), rd_data, exp_rd);
            end
        end
        do_start();
        chk("t6_re_state", state, 1);
        chk("t6_re_cyc", cyc_cnt, 0);
        chk("t6_re_ins", ins_cnt, 0);
        chk("t6_re_done", done, 0);

        // completion decode table, applied in RUN
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, dec_tab[i].ev, dec_tab[i].op);
            chk($sformatf("dec%0d", i), state, dec_tab[i].exp_state);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
